// File: rtl/i2c_seq_pkg.sv
// ============================================================================
// Module   : i2c_seq_pkg
// Brief    : Shared table-entry layout and FSM encoding for i2c_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_seq_pkg;

    localparam int ENT_W        = 33;
    localparam int ENT_ADDR_MSB = 32;
    localparam int ENT_ADDR_LSB = 26;
    localparam int ENT_REG_MSB  = 25;
    localparam int ENT_REG_LSB  = 18;
    localparam int ENT_RW       = 17;
    localparam int ENT_LEN      = 16;
    localparam int ENT_DIN_MSB  = 15;
    localparam int ENT_DIN_LSB  = 0;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;
    localparam logic [2:0] ST_FINISH  = 3'd5;

    typedef struct packed {
        logic [6:0]  addr;
        logic [7:0]  regaddr;
        logic        rw;
        logic        len;
        logic [15:0] din;
    } entry_t;

    function automatic entry_t unpack_entry(input logic [ENT_W-1:0] raw);
        entry_t e;
        e.addr    = raw[ENT_ADDR_MSB:ENT_ADDR_LSB];
        e.regaddr = raw[ENT_REG_MSB:ENT_REG_LSB];
        e.rw      = raw[ENT_RW];
        e.len     = raw[ENT_LEN];
        e.din     = raw[ENT_DIN_MSB:ENT_DIN_LSB];
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_busy_sync.sv
// ============================================================================
// Module   : i2c_busy_sync
// Brief    : Two-flop synchronizer for the controller busy flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_busy_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] stage_q;
    logic [1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[0], i_async};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 2'b00;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_sync = stage_q[1];

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
// Module   : i2c_cmd_sequencer
// Brief    : Replays a host-written table of I2C transactions into i2c_controller.
// Options  : I2C_SEQ_READBACK_EN builds the ctl_dout capture / rd_* outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IW            = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we,
    input  logic [IW-1:0]     tbl_waddr,
    input  logic [ENT_W-1:0]  tbl_wdata,
    input  logic [IW:0]       cmd_count,
    input  logic              start,
    output logic              ctl_en,
    output logic [6:0]        ctl_addr,
    output logic [7:0]        ctl_reg,
    output logic              ctl_rw,
    output logic              ctl_len,
    output logic [15:0]       ctl_din,
    input  logic              ctl_busy,
    input  logic [15:0]       ctl_dout,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    output logic [IW-1:0]     rd_index,
    output logic              running,
    output logic              done,
    output logic              error
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW:0]   c_depth    = (IW+1)'(DEPTH);
    localparam logic [IW:0]   c_idx_one  = (IW+1)'(1);
    localparam logic [GW-1:0] c_gap_last = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] c_gap_one  = GW'(1);
    localparam logic [TW-1:0] c_tmo_max  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] c_tmo_one  = TW'(1);

    logic [ENT_W-1:0] tbl_mem [DEPTH];

    logic [2:0]    state_q,   state_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [IW:0]   cnt_q,     cnt_d;
    logic [GW-1:0] gap_q,     gap_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          ctl_en_q,  ctl_en_d;
    logic [6:0]    ctl_addr_q, ctl_addr_d;
    logic [7:0]    ctl_reg_q, ctl_reg_d;
    logic          ctl_len_q, ctl_len_d;
    logic [15:0]   ctl_din_q, ctl_din_d;
    logic          running_q, running_d;
    logic          done_q,    done_d;
    logic          error_q,   error_d;

    logic          w_busy_s;
    entry_t        w_entry;
    logic [IW:0]   w_cnt_clamp;
    logic [IW:0]   w_idx_inc;
    logic [TW-1:0] w_tmo_inc;
    logic          w_load;
    logic          w_wait_done;

    i2c_busy_sync u_busy_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ctl_busy),
        .o_sync  (w_busy_s)
    );

    // Host writes land only while idle; a write racing an accepted start is dropped.
    always_ff @(posedge clk) begin
        if (tbl_we && !running_q && !start) begin
            tbl_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    assign w_entry     = unpack_entry(tbl_mem[idx_q]);
    assign w_cnt_clamp = (cmd_count > c_depth) ? c_depth : cmd_count;
    assign w_idx_inc   = {1'b0, idx_q} + c_idx_one;
    assign w_tmo_inc   = (tmo_q == c_tmo_max) ? tmo_q : (tmo_q + c_tmo_one);
    assign w_load      = (state_q == ST_LOAD);
    assign w_wait_done = (state_q == ST_WAIT_LO) && !w_busy_s;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        ctl_en_d   = ctl_en_q;
        ctl_addr_d = ctl_addr_q;
        ctl_reg_d  = ctl_reg_q;
        ctl_len_d  = ctl_len_q;
        ctl_din_d  = ctl_din_q;
        running_d  = running_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = w_cnt_clamp;
                    idx_d     = '0;
                    error_d   = 1'b0;
                    running_d = 1'b1;
                    state_d   = (w_cnt_clamp == '0) ? ST_FINISH : ST_LOAD;
                end
            end

            ST_LOAD: begin
                ctl_addr_d = w_entry.addr;
                ctl_reg_d  = w_entry.regaddr;
                ctl_len_d  = w_entry.len;
                ctl_din_d  = w_entry.din;
                ctl_en_d   = 1'b1;
                tmo_d      = '0;
                state_d    = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (w_busy_s) begin
                    ctl_en_d = 1'b0;
                    state_d  = ST_WAIT_LO;
                end else if (w_tmo_inc == c_tmo_max) begin
                    // Controller never acknowledged: abandon the rest of the script.
                    ctl_en_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_FINISH;
                end else begin
                    tmo_d = w_tmo_inc;
                end
            end

            ST_WAIT_LO: begin
                if (!w_busy_s) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_q >= c_gap_last) begin
                    if (w_idx_inc == cnt_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = w_idx_inc[IW-1:0];
                        state_d = ST_LOAD;
                    end
                end else begin
                    gap_d = gap_q + c_gap_one;
                end
            end

            ST_FINISH: begin
                done_d    = 1'b1;
                running_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                ctl_en_d  = 1'b0;
                running_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            ctl_en_q   <= 1'b0;
            ctl_addr_q <= '0;
            ctl_reg_q  <= '0;
            ctl_len_q  <= 1'b0;
            ctl_din_q  <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            ctl_en_q   <= ctl_en_d;
            ctl_addr_q <= ctl_addr_d;
            ctl_reg_q  <= ctl_reg_d;
            ctl_len_q  <= ctl_len_d;
            ctl_din_q  <= ctl_din_d;
            running_q  <= running_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ctl_en   = ctl_en_q;
    assign ctl_addr = ctl_addr_q;
    assign ctl_reg  = ctl_reg_q;
    assign ctl_len  = ctl_len_q;
    assign ctl_din  = ctl_din_q;
    assign running  = running_q;
    assign done     = done_q;
    assign error    = error_q;

`ifdef I2C_SEQ_READBACK_EN
    logic          ctl_rw_q,   ctl_rw_d;
    logic          rd_valid_q, rd_valid_d;
    logic [15:0]   rd_data_q,  rd_data_d;
    logic [IW-1:0] rd_index_q, rd_index_d;

    always_comb begin
        ctl_rw_d   = ctl_rw_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_index_d = rd_index_q;
        if (w_load) begin
            ctl_rw_d = w_entry.rw;
        end
        if (w_wait_done && ctl_rw_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = ctl_dout;
            rd_index_d = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_rw_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_index_q <= '0;
        end else begin
            ctl_rw_q   <= ctl_rw_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_index_q <= rd_index_d;
        end
    end

    assign ctl_rw   = ctl_rw_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_index = rd_index_q;
`else
    logic w_unused_rb;

    // Write-only build: the stored rw bit and ctl_dout have no consumer.
    assign w_unused_rb = ^{ctl_dout, w_entry.rw, w_wait_done};
    assign ctl_rw      = 1'b0;
    assign rd_valid    = 1'b0;
    assign rd_data     = '0;
    assign rd_index    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
// ============================================================================
// Module   : tb_i2c_cmd_sequencer
// Brief    : Self-checking bench with a behavioural controller and table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int GAP   = 64;
    localparam int TMO   = 100;
`ifdef I2C_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tbl_we;
    logic [IW-1:0] tbl_waddr;
    logic [32:0]   tbl_wdata;
    logic [IW:0]   cmd_count;
    logic          start;
    logic          ctl_en;
    logic [6:0]    ctl_addr;
    logic [7:0]    ctl_reg;
    logic          ctl_rw;
    logic          ctl_len;
    logic [15:0]   ctl_din;
    logic          ctl_busy;
    logic [15:0]   ctl_dout;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic [IW-1:0] rd_index;
    logic          running;
    logic          done;
    logic          error;

    i2c_cmd_sequencer #(
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tbl_we    (tbl_we),
        .tbl_waddr (tbl_waddr),
        .tbl_wdata (tbl_wdata),
        .cmd_count (cmd_count),
        .start     (start),
        .ctl_en    (ctl_en),
        .ctl_addr  (ctl_addr),
        .ctl_reg   (ctl_reg),
        .ctl_rw    (ctl_rw),
        .ctl_len   (ctl_len),
        .ctl_din   (ctl_din),
        .ctl_busy  (ctl_busy),
        .ctl_dout  (ctl_dout),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_index  (rd_index),
        .running   (running),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [32:0] tbl_m [DEPTH];
    logic [32:0] obs_q [$];
    logic [15:0] dout_q [$];
    logic [19:0] rd_q [$];

    bit          hang = 1'b0;
    bit          fix_en = 1'b0;
    logic [15:0] fix_val = 16'h0;
    int          en_rise, en_hi, done_cnt, done_cyc, viol, last_fall, en_fall;
    bit          have_fall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: acknowledges ctl_en after a short random delay and
    // holds busy for a random frame length, logging what it was asked to do.
    initial begin : ctl_model
        logic [32:0] snap;
        int          dly;
        int          len;
        int          rise_c;
        bit          ab;
        ctl_busy = 1'b0;
        ctl_dout = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (ctl_en && !ctl_busy && !hang && !rst) begin
                snap = {ctl_addr, ctl_reg, ctl_rw, ctl_len, ctl_din};
                obs_q.push_back(snap);
                dly = $urandom_range(0, 3);
                repeat (dly) begin @(posedge clk); #1; end
                ctl_dout = fix_en ? fix_val : 16'($urandom);
                dout_q.push_back(ctl_dout);
                ctl_busy = 1'b1;
                rise_c   = cyc;
                ab       = 1'b0;
                len      = $urandom_range(12, 40);
                repeat (len) begin
                    @(posedge clk); #1;
                    if (rst) ab = 1'b1;
                    if (!ab && ({ctl_addr, ctl_reg, ctl_rw, ctl_len, ctl_din} !== snap)) viol++;
                end
                ctl_busy  = 1'b0;
                last_fall = cyc;
                have_fall = 1'b1;
                if (!ab) check("en_drop_latency", en_fall - rise_c, 3);
            end
        end
    end

    initial begin : monitor
        bit en_prev;
        en_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ctl_en && !en_prev) begin
                en_rise++;
                if (have_fall) check("gap_to_next_en", cyc - last_fall, GAP + 4);
            end
            if (!ctl_en && en_prev) en_fall = cyc;
            if (ctl_en) en_hi++;
            if (rd_valid) begin
                rd_q.push_back({rd_index, rd_data});
                check("rd_latency", cyc - last_fall, 3);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (have_fall) check("done_latency", cyc - last_fall, GAP + 4);
            end
            en_prev = ctl_en;
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int i, input logic [32:0] d);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_waddr = IW'(i);
        tbl_wdata = d;
        @(negedge clk);
        tbl_we    = 1'b0;
        tbl_m[i]  = d;
    endtask

    function automatic logic [32:0] rand_entry();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[32:0];
    endfunction

    task automatic clear_run();
        obs_q.delete();
        dout_q.delete();
        rd_q.delete();
        en_rise   = 0;
        en_hi     = 0;
        done_cnt  = 0;
        viol      = 0;
        have_fall = 1'b0;
    endtask

    task automatic kick(input int cnt, output int st);
        @(negedge clk);
        cmd_count = (IW+1)'(cnt);
        start     = 1'b1;
        @(posedge clk); #1;
        st = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt != 0, 1);
        tick(3);
        check("done_once", done_cnt, 1);
        check("running_after_done", running, 0);
    endtask

    task automatic verify(input int cnt);
        int          n;
        logic [32:0] e;
        logic [19:0] exp_rd [$];
        n = (cnt > DEPTH) ? DEPTH : cnt;
        check("txn_count", obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            e = tbl_m[i];
            if (!RB) e[17] = 1'b0;
            check("txn_fields", obs_q[i], e);
            if (i < dout_q.size() && RB && tbl_m[i][17]) exp_rd.push_back({IW'(i), dout_q[i]});
        end
        check("rd_count", rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) begin
            check("rd_result", rd_q[i], exp_rd[i]);
        end
        check("ctl_stable_in_busy", viol, 0);
    endtask

    task automatic run(input int cnt);
        int st;
        clear_run();
        kick(cnt, st);
        wait_done(20000);
        verify(cnt);
    endtask

    task automatic check_reset_outputs();
        check("rst_ctl", {ctl_en, ctl_addr, ctl_reg, ctl_rw, ctl_len, ctl_din}, 0);
        check("rst_rd", {rd_valid, rd_data, rd_index}, 0);
        check("rst_flags", {running, done, error}, 0);
    endtask

    initial begin : main
        int          st;
        int          n;
        int          cnt;
        logic [32:0] e;
        rst       = 1'b1;
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = '0;
        cmd_count = '0;
        start     = 1'b0;
        tick(3);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr(i, rand_entry());

        // Single write
        wr(0, {7'h3C, 8'h10, 1'b0, 1'b0, 16'hAB00});
        run(1);
        check("single_en_count", en_rise, 1);
        check("single_ctl_reg", ctl_reg, 8'h10);
        check("single_error", error, 0);

        // Three-entry script with mixed lengths, all writes
        for (int i = 0; i < 3; i++) begin
            e = rand_entry();
            e[17] = 1'b0;
            e[16] = i[0];
            wr(i, e);
        end
        run(3);
        check("script_en_count", en_rise, 3);
        check("script_error", error, 0);

        // Readback on entry 1
        e = tbl_m[1];
        e[17] = 1'b1;
        e[16] = 1'b1;
        wr(1, e);
        fix_en  = 1'b1;
        fix_val = 16'hBEEF;
        run(3);
        check("readback_count", rd_q.size(), RB ? 1 : 0);
        fix_en = 1'b0;

        // Randomized full tables, second pass with cmd_count above DEPTH
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < DEPTH; i++) wr(i, rand_entry());
            cnt = (rep == 0) ? $urandom_range(1, DEPTH) : DEPTH + $urandom_range(1, 15);
            run(cnt);
            check("random_error", error, 0);
        end

        // Timeout: controller never acknowledges
        hang = 1'b1;
        clear_run();
        kick(3, st);
        wait_done(2000);
        check("tmo_en_count", en_rise, 1);
        check("tmo_en_cycles", en_hi, TMO);
        check("tmo_error", error, 1);
        check("tmo_no_txn", obs_q.size(), 0);
        hang = 1'b0;
        run(1);
        check("error_cleared", error, 0);

        // Zero-length run
        clear_run();
        kick(0, st);
        tick(4);
        check("zero_done_cycle", done_cyc - st, 1);
        check("zero_done_count", done_cnt, 1);
        check("zero_no_en", en_rise, 0);

        // start and table write while running are ignored
        clear_run();
        kick(2, st);
        tick(30);
        check("running_mid_run", running, 1);
        @(negedge clk);
        cmd_count = 5'd5;
        start     = 1'b1;
        tbl_we    = 1'b1;
        tbl_waddr = '0;
        tbl_wdata = ~tbl_m[0];
        @(negedge clk);
        start  = 1'b0;
        tbl_we = 1'b0;
        wait_done(20000);
        verify(2);
        run(1);

        // Table write in the same cycle as an accepted start is dropped
        clear_run();
        @(negedge clk);
        cmd_count = 5'd1;
        start     = 1'b1;
        tbl_we    = 1'b1;
        tbl_waddr = '0;
        tbl_wdata = ~tbl_m[0];
        @(negedge clk);
        start  = 1'b0;
        tbl_we = 1'b0;
        wait_done(20000);
        verify(1);

        // Reset while waiting for busy to fall
        e = tbl_m[0];
        e[17] = 1'b1;
        wr(0, e);
        clear_run();
        kick(2, st);
        n = 0;
        while (!ctl_busy && n < 200) begin @(negedge clk); n++; end
        check("busy_before_reset", ctl_busy, 1);
        tick(6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        n = 0;
        while (ctl_busy && n < 200) begin @(negedge clk); n++; end
        tick(8);
        check("no_rd_after_reset", rd_q.size(), 0);
        check("no_done_after_reset", done_cnt, 0);
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
